alu_issue_ctrl: RTL
===================

// Module: alu_issue_ctrl
// PURPOSE
//  Issuing end of the 16-bit ALU interface. Accepts one instruction word per valid/ready handshake and reads operands from an internal 8x16 register file.
//  Drives ALU A/B/ALUControl from registers, then captures Result and flags.
//  Writes the result back to rd and holds a 4-bit NZCV status register. Sits between the instruction source and the combinational ALU.
// PARAMETERS
//  DATA_W    16  datapath width; must equal the ALU width (16)
//  R0_ZERO   1   1: r0 reads 0 and writes to it are discarded; 0: r0 is an ordinary register
// PORTS
//  clk           in   1   single clock, rising edge
//  rst_n         in   1   asynchronous active-low reset
//  instr_valid   in   1   instruction word offered
//  instr_ready   out  1   controller can accept (high only in IDLE)
//  instr         in   16  [15:13]op [12:10]rd [9:7]rs1 [6]imm_sel [5:0]rs2/imm
//  host_wr_en    in   1   register-file load strobe (honoured in IDLE only)
//  host_wr_addr  in   3   register-file load address
//  host_wr_data  in   16  register-file load data
//  dbg_addr      in   3   debug read address
//  dbg_data      out  16  combinational rf[dbg_addr] (0 for r0 when R0_ZERO=1)
//  alu_a         out  16  registered ALU operand A
//  alu_b         out  16  registered ALU operand B
//  alu_ctrl      out  3   registered ALUControl: 000ADD 001SUB 010AND 011OR 100XOR 101SLT 110SLTU 111ROR
//  alu_result    in   16  ALU Result
//  alu_flags     in   4   {Negative,Zero,Carry,OverFlow} from ALU
//  done          out  1   one-cycle pulse: writeback completed
//  done_rd       out  3   destination of completed op (valid with done)
//  done_data     out  16  result of completed op (valid with done)
//  flags_nzcv    out  4   status register {N,Z,C,V}
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; rf all 0; flags_nzcv=0; alu_a/alu_b/alu_ctrl=0; done=0; done_rd=0; done_data=0; instr_ready=1.
//  FSM IDLE -> EXEC -> DONE -> IDLE. Transitions are unconditional except IDLE->EXEC.
//  IDLE: instr_ready=1. On instr_valid&&instr_ready (edge E0), latch the following and go to EXEC:
//   - alu_ctrl=op
//   - alu_a=rf[rs1]
//   - alu_b = imm_sel ? {10'b0,instr[5:0]} : rf[instr[5:3]]
//   - rd
//  EXEC: instr_ready=0, ALU settles combinationally. At edge E1:
//   - rf[rd]<=alu_result (suppressed if rd=0 and R0_ZERO=1)
//   - flags_nzcv<=alu_flags (always, including for rd=0)
//   - done_data<=alu_result; done_rd<=rd
//   - go to DONE
//  DONE: done=1 for exactly this cycle, instr_ready=0. Go to IDLE at E2.
//  Throughput is one op per 3 cycles. New rf value is visible on dbg_data and to later instructions from E1.
//  alu_a/alu_b/alu_ctrl hold their values after EXEC until the next accept.
//  No operand bypass. An instruction accepted in the same IDLE cycle as a host write reads the pre-edge rf contents.
//  host_wr_en: write occurs at the edge only when state==IDLE; it is ignored in EXEC/DONE (no queuing).
//  Host write to r0 is discarded when R0_ZERO=1.
//  instr_valid while busy: no accept and no side effects. Source must hold instr until ready.
//  Reset mid-op (EXEC or DONE): op aborted. No rf or flag write; all outputs return to reset values.
//  Flags are copied verbatim from the ALU; the controller computes no flags itself.
// TESTING
//  1. Host r1=0x7FFF, r2=0x0001; ADD r3,r1,r2 -> done 2 cycles after accept, r3=0x8000, flags_nzcv=1000|C|1 (N=1, V=1).
//  2. SUB r4,r2,r2 -> r4=0x0000, done_data=0, flags N=0 Z=1 V=0.
//  3. Host r1=0x8001; ROR r5,r1,#4 (imm_sel=1, imm=4) -> alu_b=0x0004, r5=0x1800.
//  4. R0_ZERO=1, ADD r0,r1,r2 -> done pulses with done_rd=0; dbg r0 reads 0; flags updated. Host write r0=0xFFFF -> dbg reads 0.
//  5. instr_valid held high for 2 instrs -> accepts exactly 3 cycles apart. instr_ready=0 in EXEC/DONE. Host write in EXEC is ignored (target unchanged).
//  6. rst_n low during EXEC of ADD r6 -> r6 stays 0, flags 0, done never pulses, instr_ready=1 after reset release.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue/writeback controller in front of a combinational 16-bit ALU
//
// Accepts one instruction per valid/ready handshake, reads operands from an
// internal 8-entry register file, presents them to the ALU as registered
// operands, then writes the ALU result back and latches the NZCV flags.
// One operation takes three cycles: IDLE (accept) -> EXEC -> DONE.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   instr_valid / instr_ready / instr instruction handshake;
//                                     instr = {op[2:0], rd[2:0], rs1[2:0], imm_sel, rs2_imm[5:0]}
//   host_wr_en / _addr / _data        register-file load port (IDLE only)
//   dbg_addr / dbg_data               combinational register-file read port
//   alu_a / alu_b / alu_ctrl          registered ALU operands and opcode
//   alu_result / alu_flags            ALU outputs {N,Z,C,V}
//   done / done_rd / done_data        one-cycle writeback-complete pulse with destination and value
//   flags_nzcv                        status register {N,Z,C,V}

module alu_issue_ctrl #(
  parameter int DATA_W  = 16,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  input  logic              host_wr_en,
  input  logic [2:0]        host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic              done,
  output logic [2:0]        done_rd,
  output logic [DATA_W-1:0] done_data,
  output logic [3:0]        flags_nzcv
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] rf [8];
  logic [2:0]        rd_q;

  logic [2:0]        f_op;
  logic [2:0]        f_rd;
  logic [2:0]        f_rs1;
  logic [2:0]        f_rs2;
  logic              f_imm_sel;
  logic [DATA_W-1:0] imm_ext;
  logic              accept;
  logic              host_en;
  logic              wb_en;

  assign f_op      = instr[15:13];
  assign f_rd      = instr[12:10];
  assign f_rs1     = instr[9:7];
  assign f_imm_sel = instr[6];
  assign f_rs2     = instr[5:3];
  assign imm_ext   = {{(DATA_W-6){1'b0}}, instr[5:0]};

  // r0 is hard-wired to zero on every read path when R0_ZERO is set.
  function automatic logic [DATA_W-1:0] rf_read(input logic [2:0] addr);
    if (R0_ZERO && addr == 3'd0) return '0;
    return rf[addr];
  endfunction

  assign instr_ready = (state == ST_IDLE);
  assign accept      = instr_valid && instr_ready;
  assign dbg_data    = rf_read(dbg_addr);

  // Host loads only land while idle; anything offered in EXEC/DONE is dropped.
  assign host_en = host_wr_en && (state == ST_IDLE) && !(R0_ZERO && host_wr_addr == 3'd0);
  assign wb_en   = (state == ST_EXEC) && !(R0_ZERO && rd_q == 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
      rd_q       <= 3'd0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= 3'd0;
      done       <= 1'b0;
      done_rd    <= 3'd0;
      done_data  <= '0;
      flags_nzcv <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Operand reads below see the pre-edge register file, so an
          // instruction accepted alongside a host write gets the old value.
          if (host_en) rf[host_wr_addr] <= host_wr_data;
          if (accept) begin
            alu_ctrl <= f_op;
            alu_a    <= rf_read(f_rs1);
            alu_b    <= f_imm_sel ? imm_ext : rf_read(f_rs2);
            rd_q     <= f_rd;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (wb_en) rf[rd_q] <= alu_result;
          // Flags update even when the destination is a discarded r0.
          flags_nzcv <= alu_flags;
          done_data  <= alu_result;
          done_rd    <= rd_q;
          done       <= 1'b1;
          state      <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
